operand_fetch: RTL
==================

# operand_fetch

Operand-fetch stage sitting directly upstream of the ALU in the RISC datapath. Holds the 8×16 register file, fetches two source registers over a sequenced read, applies the shifter to the B operand, and presents `ain`/`bin` to the ALU under a valid/ready handshake. Register writeback from later stages enters through a dedicated write port.

## Interface
Parameters:
- `DATA_W`, 16, operand/register width
- `NREG`, 8, register count; index width is `$clog2(NREG)` = 3

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  fetch request; sampled only when `busy`=0
- `busy`  out  1  high in any state other than IDLE
- `rn`  in  3  A-source register index
- `rm`  in  3  B-source register index
- `shift`  in  2  B shift: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1 (bit15 kept)
- `asel`  in  1  1: `ain` forced to 0
- `bsel`  in  1  1: `bin` = `sximm5` instead of shifted R[rm]
- `sximm5`  in  16  sign-extended immediate
- `wr_en`  in  1  register write enable
- `wr_num`  in  3  write index
- `wr_data`  in  16  write data
- `ain`  out  16  ALU A operand
- `bin`  out  16  ALU B operand
- `out_valid`  out  1  operands stable and valid
- `out_ready`  in  1  ALU accepts operands

## Operation
- Reset (async, `rst_n`=0): R0–R7 = 0, A/B holding regs = 0, command regs = 0, state IDLE; `busy`=0, `out_valid`=0, `ain`=`bin`=0.
- States: IDLE, READ_A, READ_B, HOLD.
  - IDLE: `start`=1 → latch `rn, rm, shift, asel, bsel, sximm5` into command regs; → READ_A. `start`=0 → stay.
  - READ_A: A_reg ← R[rn_q]; → READ_B.
  - READ_B: B_reg ← bsel_q ? sximm5_q : shift(R[rm_q], shift_q); → HOLD.
  - HOLD: `out_valid`=1; `out_ready`=1 → IDLE; else stay.
- Outputs: `ain` = asel_q ? 0 : A_reg; `bin` = B_reg. Outputs change only on register updates; stable throughout HOLD.
- `start` while `busy`=1: ignored, no queueing. `start` on the cycle HOLD→IDLE: ignored; the next IDLE cycle accepts.
- Register write: on any edge with `wr_en`=1, R[wr_num] ← wr_data, in every state.
- Write bypass: in READ_A/READ_B, if `wr_en`=1 and `wr_num` equals the index being read, the captured value is `wr_data` (pre-shift for B), not the stale register.
- Writes during HOLD update the register file only; A_reg/B_reg snapshots are unchanged.
- Shifts are on the 16-bit value; bits shifted out are discarded; no flags produced here (flags belong to the ALU).
- Reset asserted mid-fetch: immediate abort to IDLE, all state per reset values; no partial output.

## Timing
- `start` sampled at edge 0 (IDLE) → READ_A after edge 0, READ_B after edge 1, HOLD after edge 2: `out_valid`=1 from edge 2, i.e. 3 cycles start→valid.
- Handshake completes on the edge where `out_valid`=1 and `out_ready`=1; `out_valid` drops after that edge.
- Minimum back-to-back issue: 4 cycles per operand pair with `out_ready` held high.
- Write-port latency: 1 edge; bypass makes a same-cycle write visible to the read in that cycle.

## Structure
- Package `datapath_pkg`: `fetch_state_t` enum {IDLE, READ_A, READ_B, HOLD}; shift encoding constants `SH_NONE`, `SH_LSL`, `SH_LSR`, `SH_ASR`; `DATA_W`/`REG_IDX_W` localparams shared with the ALU.
- Sub-module `regfile`: NREG×DATA_W, one sync write port, one combinational read port, async active-low reset to 0. Shifter stays inline as a combinational function in the package.

## Test plan
- Reset: write R3=0x1234, assert `rst_n`=0 mid-READ_B → state IDLE, `busy`=0, `out_valid`=0, fetch of R3 returns 0x0000.
- Basic fetch: R1=0x0003, R2=0x0004, start rn=1 rm=2 shift=00 → `out_valid` after 3 cycles with `ain`=0x0003, `bin`=0x0004; ALU ADD gives 0x0007.
- Shifts: R2=0x8001, shift 01/10/11 → `bin`=0x0002 / 0x4000 / 0xC000.
- Selects: asel=1, bsel=1, sximm5=0xFFF0 → `ain`=0x0000, `bin`=0xFFF0 regardless of register contents.
- Bypass and snapshot: write R1=0x00AA in the READ_A cycle with rn=1 → `ain`=0x00AA; then write R1=0x0055 during HOLD → `ain` stays 0x00AA.
- Backpressure/ignore: hold `out_ready`=0 for 5 cycles while pulsing `start` → `out_valid` stays high, operands unchanged, no second fetch; release → one handshake, `busy` falls next cycle.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath definitions: widths, fetch FSM states, B-operand shifter.
package datapath_pkg;

  localparam int DATA_W    = 16;
  localparam int NREG      = 8;
  localparam int REG_IDX_W = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    HOLD   = 2'd3
  } fetch_state_t;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // Single-bit shifter on the B operand; shifted-out bits are dropped, no flags.
  function automatic logic [DATA_W-1:0] shift_b(input logic [DATA_W-1:0] v,
                                                input logic [1:0]        sh);
    logic [DATA_W-1:0] r;
    r = v;
    case (sh)
      SH_LSL:  r = {v[DATA_W-2:0], 1'b0};
      SH_LSR:  r = {1'b0, v[DATA_W-1:1]};
      SH_ASR:  r = {v[DATA_W-1], v[DATA_W-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/regfile.sv
// NREG x DATA_W register file: one synchronous write port, one combinational read port.
module regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int IDX_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_num,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] regs [NREG];

  // Register storage: cleared on reset, written on any enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_num] <= wr_data;
    end
  end

  assign rd_data = regs[rd_num];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: sequenced A/B register reads with write bypass,
// B-operand shift/immediate select, and a valid/ready hold toward the ALU.
//
//  state  | meaning
//  IDLE   | waiting for start; command fields latched when start=1
//  READ_A | A_reg captures R[rn] (bypassing a same-cycle write)
//  READ_B | B_reg captures imm or shifted R[rm] (bypass applied pre-shift)
//  HOLD   | operands presented with out_valid until out_ready
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  input  logic [$clog2(NREG)-1:0]  rn,
  input  logic [$clog2(NREG)-1:0]  rm,
  input  logic [1:0]               shift,
  input  logic                     asel,
  input  logic                     bsel,
  input  logic [DATA_W-1:0]        sximm5,
  input  logic                     wr_en,
  input  logic [$clog2(NREG)-1:0]  wr_num,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        ain,
  output logic [DATA_W-1:0]        bin,
  output logic                     out_valid,
  input  logic                     out_ready
);

  import datapath_pkg::*;

  localparam int IDX_W = $clog2(NREG);

  fetch_state_t state_q, state_d;

  logic [IDX_W-1:0]  rn_q, rm_q;
  logic [1:0]        shift_q;
  logic              asel_q, bsel_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] a_q, b_q;

  logic              cmd_ld, a_ld, b_ld;
  logic [IDX_W-1:0]  rd_num;
  logic [DATA_W-1:0] rf_rdata, rd_val;

  regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_num  (wr_num),
    .wr_data (wr_data),
    .rd_num  (rd_num),
    .rd_data (rf_rdata)
  );

  // The single read port serves rn in READ_A and rm in READ_B.
  assign rd_num = (state_q == READ_B) ? rm_q : rn_q;
  // A write landing on the register being read this cycle wins over the stale copy.
  assign rd_val = (wr_en && (wr_num == rd_num)) ? wr_data : rf_rdata;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control decode.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    out_valid = 1'b0;
    cmd_ld    = 1'b0;
    a_ld      = 1'b0;
    b_ld      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          cmd_ld  = 1'b1;
          state_d = READ_A;
        end
      end
      READ_A: begin
        a_ld    = 1'b1;
        state_d = READ_B;
      end
      READ_B: begin
        b_ld    = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch and operand snapshots; held untouched through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= SH_NONE;
      asel_q  <= 1'b0;
      bsel_q  <= 1'b0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      if (cmd_ld) begin
        rn_q    <= rn;
        rm_q    <= rm;
        shift_q <= shift;
        asel_q  <= asel;
        bsel_q  <= bsel;
        imm_q   <= sximm5;
      end
      if (a_ld) a_q <= rd_val;
      if (b_ld) b_q <= bsel_q ? imm_q : shift_b(rd_val, shift_q);
    end
  end

  assign ain = asel_q ? '0 : a_q;
  assign bin = b_q;

endmodule
